// File: rtl/dmem_arb_pkg.sv
// Shared types and widths for the data-memory arbiter.
package dmem_arb_pkg;

    localparam int unsigned DMEM_ADDR_W = 32;
    localparam int unsigned DMEM_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CPU_RD = 2'd1,
        EXT_RD = 2'd2
    } arb_state_t;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of cycles the external requester has been passed over.
module arb_starve_ctr #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned CNT_W        = 3
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             expired_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o     = cnt_q;
    assign expired_o = (32'(cnt_q) >= STARVE_LIMIT);

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the data-memory port between the CPU MEM stage and an external requester,
// sequencing one-cycle synchronous reads and generating the CPU stall.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned CNT_W        = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cpu_re,
    input  logic                   cpu_we,
    input  logic [DMEM_ADDR_W-1:0] cpu_addr,
    input  logic [DMEM_DATA_W-1:0] cpu_wdata,
    output logic [DMEM_DATA_W-1:0] cpu_rdata,
    output logic                   cpu_stall,
    input  logic                   ext_req,
    input  logic                   ext_we,
    input  logic [DMEM_ADDR_W-1:0] ext_addr,
    input  logic [DMEM_DATA_W-1:0] ext_wdata,
    output logic                   ext_gnt,
    output logic                   ext_rvalid,
    output logic [DMEM_DATA_W-1:0] ext_rdata,
    output logic                   mem_re,
    output logic                   mem_we,
    output logic [DMEM_ADDR_W-1:0] mem_addr,
    output logic [DMEM_DATA_W-1:0] mem_wdata,
    input  logic [DMEM_DATA_W-1:0] mem_rdata
);

    arb_state_t       state_q, state_d;
    logic             cpu_req;
    logic             ext_win;
    logic             expired;
    logic             cpu_wr_issued;
    logic [CNT_W-1:0] starve_cnt;

    assign cpu_req = cpu_re | cpu_we;
    // The CPU keeps priority until the external side has lost STARVE_LIMIT times.
    assign ext_win = ext_req & (expired | ~cpu_req);

    arb_starve_ctr #(
        .STARVE_LIMIT(STARVE_LIMIT),
        .CNT_W       (CNT_W)
    ) u_starve_ctr (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .inc_i    (ext_req & ~ext_gnt),
        .clr_i    (ext_gnt | ~ext_req),
        .cnt_o    (starve_cnt),
        .expired_o(expired)
    );

    always_comb begin
        state_d       = state_q;
        mem_re        = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = cpu_addr;
        mem_wdata     = cpu_wdata;
        ext_gnt       = 1'b0;
        ext_rvalid    = 1'b0;
        cpu_wr_issued = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (ext_win) begin
                    ext_gnt   = 1'b1;
                    mem_we    = ext_we;
                    mem_re    = ~ext_we;
                    mem_addr  = ext_addr;
                    mem_wdata = ext_wdata;
                    if (!ext_we) begin
                        state_d = EXT_RD;
                    end
                end else if (cpu_req) begin
                    // A simultaneous load and store is treated as a store.
                    mem_we        = cpu_we;
                    mem_re        = ~cpu_we;
                    cpu_wr_issued = cpu_we;
                    if (!cpu_we) begin
                        state_d = CPU_RD;
                    end
                end
            end
            CPU_RD: begin
                state_d = IDLE;
            end
            EXT_RD: begin
                ext_rvalid = 1'b1;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        cpu_stall = cpu_req & ~(cpu_wr_issued | (state_q == CPU_RD));

        // Outputs go quiet while reset is held so a read in flight cannot leak out.
        if (!rst_n) begin
            cpu_stall  = 1'b0;
            ext_gnt    = 1'b0;
            ext_rvalid = 1'b0;
            mem_re     = 1'b0;
            mem_we     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign cpu_rdata = mem_rdata;
    assign ext_rdata = mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a one-cycle-latency memory model.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_re = 1'b0, cpu_we = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0, cpu_rdata;
    logic        cpu_stall;
    logic        ext_req = 1'b0, ext_we = 1'b0;
    logic [31:0] ext_addr = '0, ext_wdata = '0, ext_rdata;
    logic        ext_gnt, ext_rvalid;
    logic        mem_re, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic [31:0] mem_q [0:63];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) mem_q[mem_addr[7:2]] <= mem_wdata;
        if (mem_re) mem_rdata <= mem_q[mem_addr[7:2]];
    end

    dmem_arbiter #(
        .STARVE_LIMIT(4),
        .CNT_W       (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cpu_re    (cpu_re),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_stall (cpu_stall),
        .ext_req   (ext_req),
        .ext_we    (ext_we),
        .ext_addr  (ext_addr),
        .ext_wdata (ext_wdata),
        .ext_gnt   (ext_gnt),
        .ext_rvalid(ext_rvalid),
        .ext_rdata (ext_rdata),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cpu_re  = 1'b0;
        cpu_we  = 1'b0;
        ext_req = 1'b0;
        ext_we  = 1'b0;
    endtask

    task automatic test_reset();
        cpu_re  = 1'b1;
        ext_req = 1'b1;
        #2;
        checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", cpu_stall); end
        checks++; if ({ext_gnt, ext_rvalid, mem_re, mem_we} !== 4'b0) begin errors++;
            $display("FAIL reset_outs got=%b exp=0000", {ext_gnt, ext_rvalid, mem_re, mem_we}); end
        idle_inputs();
        next_cycle();
        rst_n = 1'b1;
        #1;
        checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL reset_state got=%0d exp=0", dut.state_q); end
        checks++; if (dut.starve_cnt !== 3'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", dut.starve_cnt); end
        next_cycle();
    endtask

    task automatic test_cpu_store_load();
        cpu_we = 1'b1; cpu_addr = 32'h10; cpu_wdata = 32'hDEADBEEF;
        #1;
        checks++; if ({mem_we, mem_re, cpu_stall} !== 3'b100) begin errors++;
            $display("FAIL st_issue we/re/stall got=%b exp=100", {mem_we, mem_re, cpu_stall}); end
        checks++; if (mem_addr !== 32'h10 || mem_wdata !== 32'hDEADBEEF) begin errors++;
            $display("FAIL st_bus got=%h/%h exp=10/deadbeef", mem_addr, mem_wdata); end
        next_cycle();
        cpu_we = 1'b0; cpu_re = 1'b1;
        #1;
        checks++; if ({mem_re, cpu_stall} !== 2'b11) begin errors++; $display("FAIL ld_issue re/stall got=%b exp=11", {mem_re, cpu_stall}); end
        next_cycle();
        checks++; if ({mem_re, cpu_stall} !== 2'b00) begin errors++; $display("FAIL ld_ret re/stall got=%b exp=00", {mem_re, cpu_stall}); end
        checks++; if (cpu_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL ld_data got=%h exp=deadbeef", cpu_rdata); end
        next_cycle();
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_both_re_we();
        cpu_re = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h18; cpu_wdata = 32'h0BADF00D;
        #1;
        checks++; if ({mem_we, mem_re, cpu_stall} !== 3'b100) begin errors++;
            $display("FAIL rw_both we/re/stall got=%b exp=100", {mem_we, mem_re, cpu_stall}); end
        next_cycle();
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_ext_write_read();
        ext_req = 1'b1; ext_we = 1'b1; ext_addr = 32'h24; ext_wdata = 32'h12345678;
        #1;
        checks++; if ({ext_gnt, mem_we, mem_re} !== 3'b110) begin errors++;
            $display("FAIL ext_wr gnt/we/re got=%b exp=110", {ext_gnt, mem_we, mem_re}); end
        checks++; if (mem_addr !== 32'h24 || mem_wdata !== 32'h12345678) begin errors++;
            $display("FAIL ext_wr_bus got=%h/%h exp=24/12345678", mem_addr, mem_wdata); end
        next_cycle();
        ext_we = 1'b0;
        #1;
        checks++; if ({ext_gnt, mem_re, ext_rvalid} !== 3'b110) begin errors++;
            $display("FAIL ext_rd gnt/re/rvalid got=%b exp=110", {ext_gnt, mem_re, ext_rvalid}); end
        next_cycle();
        ext_req = 1'b0;
        #1;
        checks++; if ({ext_rvalid, ext_gnt} !== 2'b10) begin errors++; $display("FAIL ext_rvalid got=%b exp=10", {ext_rvalid, ext_gnt}); end
        checks++; if (ext_rdata !== 32'h12345678) begin errors++; $display("FAIL ext_rdata got=%h exp=12345678", ext_rdata); end
        next_cycle();
        checks++; if (ext_rvalid !== 1'b0) begin errors++; $display("FAIL ext_rvalid_pulse got=%b exp=0", ext_rvalid); end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) begin
            cpu_we = 1'b1; cpu_addr = 32'h40 + 32'(i * 4); cpu_wdata = 32'hC0DE0000 + 32'(i);
            #1;
            checks++; if ({mem_we, cpu_stall} !== 2'b10 || mem_addr !== cpu_addr) begin errors++;
                $display("FAIL b2b_st[%0d] we/stall got=%b addr=%h exp=10 addr=%h", i, {mem_we, cpu_stall}, mem_addr, cpu_addr); end
            next_cycle();
        end
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_starvation();
        logic [31:0] exp_addr;
        ext_req = 1'b1; ext_we = 1'b1; ext_addr = 32'h30; ext_wdata = 32'hA5A5A5A5;
        for (int i = 0; i < 5; i++) begin
            cpu_we = 1'b1; cpu_addr = 32'h80 + 32'(i * 4); cpu_wdata = 32'(i);
            exp_addr = (i == 4) ? 32'h30 : cpu_addr;
            #1;
            checks++; if (dut.starve_cnt !== 3'(i)) begin errors++; $display("FAIL starve_cnt[%0d] got=%0d exp=%0d", i, dut.starve_cnt, i); end
            checks++; if ({ext_gnt, cpu_stall, mem_we} !== {(i == 4), (i == 4), 1'b1} || mem_addr !== exp_addr) begin errors++;
                $display("FAIL starve[%0d] gnt/stall/we got=%b addr=%h exp=%b addr=%h",
                         i, {ext_gnt, cpu_stall, mem_we}, mem_addr, {(i == 4), (i == 4), 1'b1}, exp_addr); end
            if (i < 4) next_cycle();
        end
        next_cycle();
        ext_req = 1'b0;
        #1;
        checks++; if (dut.starve_cnt !== 3'd0) begin errors++; $display("FAIL starve_clr got=%0d exp=0", dut.starve_cnt); end
        checks++; if ({mem_we, cpu_stall} !== 2'b10 || mem_addr !== 32'h90) begin errors++;
            $display("FAIL starve_cpu_resume we/stall got=%b addr=%h exp=10 addr=90", {mem_we, cpu_stall}, mem_addr); end
        next_cycle();
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_cpu_first();
        cpu_re = 1'b1; cpu_addr = 32'h10;
        ext_req = 1'b1; ext_we = 1'b0; ext_addr = 32'h24;
        #1;
        checks++; if ({mem_re, cpu_stall, ext_gnt} !== 3'b110 || mem_addr !== 32'h10) begin errors++;
            $display("FAIL both_c0 re/stall/gnt got=%b addr=%h exp=110 addr=10", {mem_re, cpu_stall, ext_gnt}, mem_addr); end
        next_cycle();
        checks++; if ({cpu_stall, ext_gnt, mem_re} !== 3'b000 || cpu_rdata !== 32'hDEADBEEF) begin errors++;
            $display("FAIL both_c1 stall/gnt/re got=%b data=%h exp=000 data=deadbeef", {cpu_stall, ext_gnt, mem_re}, cpu_rdata); end
        next_cycle();
        cpu_re = 1'b0;
        #1;
        checks++; if ({ext_gnt, mem_re} !== 2'b11 || mem_addr !== 32'h24) begin errors++;
            $display("FAIL both_c2 gnt/re got=%b addr=%h exp=11 addr=24", {ext_gnt, mem_re}, mem_addr); end
        next_cycle();
        ext_req = 1'b0;
        #1;
        checks++; if (ext_rvalid !== 1'b1 || ext_rdata !== 32'h12345678) begin errors++;
            $display("FAIL both_c3 rvalid=%b data=%h exp=1 data=12345678", ext_rvalid, ext_rdata); end
        next_cycle();
    endtask

    task automatic test_reset_mid_read();
        ext_req = 1'b1; ext_we = 1'b0; ext_addr = 32'h24;
        #1;
        checks++; if (ext_gnt !== 1'b1) begin errors++; $display("FAIL rst_rd_gnt got=%b exp=1", ext_gnt); end
        next_cycle();
        ext_req = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++; if (ext_rvalid !== 1'b0) begin errors++; $display("FAIL rst_rd_rvalid got=%b exp=0", ext_rvalid); end
        next_cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if ({ext_rvalid, cpu_stall, mem_re, mem_we} !== 4'b0) begin errors++;
                $display("FAIL rst_rd_after[%0d] rvalid/stall/re/we got=%b exp=0000", i, {ext_rvalid, cpu_stall, mem_re, mem_we}); end
            checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL rst_rd_state[%0d] got=%0d exp=0", i, dut.state_q); end
            next_cycle();
        end
    endtask

    initial begin
        test_reset();
        test_cpu_store_load();
        test_both_re_we();
        test_ext_write_read();
        test_back_to_back();
        test_starvation();
        test_cpu_first();
        test_reset_mid_read();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Sequencer and arbiter for the CPU data-memory banks. Shares the single memory port between the CPU MEM stage and one external requester, such as a loader or DMA engine. Reads use the banks' one-cycle synchronous read latency. The block sits between the MEM stage and the banked memory; bank decode stays downstream on `mem_addr[3:2]`. It drives the CPU stall, replacing the constant-zero memory stall.

## Interface
- `STARVE_LIMIT`, default 4: consecutive cycles an external request may lose to the CPU before it takes priority.
- `CNT_W`, default 3: starvation counter width; must satisfy 2^CNT_W > STARVE_LIMIT.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `cpu_re` in 1: CPU load request; held until `cpu_stall`=0.
- `cpu_we` in 1: CPU store request; held until `cpu_stall`=0.
- `cpu_addr` in 32: CPU byte address (ALU result).
- `cpu_wdata` in 32: CPU store data.
- `cpu_rdata` out 32: load data; valid when `cpu_re`=1 and `cpu_stall`=0.
- `cpu_stall` out 1: freezes the pipeline.
- `ext_req` in 1: external request; `ext_we`/`ext_addr`/`ext_wdata` are stable while `ext_req`=1 and until grant.
- `ext_we` in 1: 1=write, 0=read.
- `ext_addr` in 32: external byte address.
- `ext_wdata` in 32: external write data.
- `ext_gnt` out 1: one-cycle pulse; the request is issued to memory this cycle.
- `ext_rvalid` out 1: one-cycle pulse, the cycle after a read grant.
- `ext_rdata` out 32: read data; valid with `ext_rvalid`.
- `mem_re` out 1: memory read enable.
- `mem_we` out 1: memory write enable.
- `mem_addr` out 32: address to the banks.
- `mem_wdata` out 32: write data to the banks.
- `mem_rdata` in 32: bank read data, valid one cycle after `mem_re`.

## Operation
FSM states:
- **IDLE**: the issue slot is free.
- **CPU_RD**: CPU read data is returning.
- **EXT_RD**: external read data is returning.

Issue rules in IDLE:
- Winner is the CPU if `cpu_re|cpu_we`, unless `ext_req` and `starve_cnt`≥STARVE_LIMIT; otherwise the external requester if `ext_req`.
- Winner's address and data are driven on `mem_*` combinationally.
- A read winner moves the FSM to CPU_RD or EXT_RD.
- A write completes in its issue cycle; the FSM stays in IDLE.
- If both `cpu_re` and `cpu_we` are set, the request is treated as a write.

CPU_RD and EXT_RD:
- No new issue; `mem_re`=`mem_we`=0.
- `cpu_rdata`/`ext_rdata` = `mem_rdata`.
- Return to IDLE next cycle.

`cpu_stall` = (`cpu_re|cpu_we`) and not (CPU write issued this cycle, or state=CPU_RD).

`starve_cnt`:
- Increments, saturating at 2^CNT_W−1, each cycle `ext_req`=1 and `ext_gnt`=0.
- Clears on `ext_gnt`, and when `ext_req`=0.

Boundaries:
- External request dropped before grant: protocol violation; no access issued.
- `ext_req` rising in a RD state: waits; counter still increments.
- Back-to-back CPU writes: one per cycle, zero stall.
- Reset mid-read: the outstanding read is discarded; no `ext_rvalid` or CPU unstall pulse after reset.

## Timing
- All outputs are combinational from state and inputs.
- While `rst_n`=0: state=IDLE, `starve_cnt`=0, and `cpu_stall`, `ext_gnt`, `ext_rvalid`, `mem_re`, `mem_we` are forced 0.
- `cpu_rdata`, `ext_rdata`, `mem_addr`, `mem_wdata` are don't-care during reset.

Latency:
- CPU write: 0 stall cycles if it wins.
- CPU read: 1 stall cycle minimum; data in cycle N+1 for issue in cycle N.
- External write: grant is the completion cycle.
- External read: `ext_rvalid` exactly 1 cycle after `ext_gnt`.

Worst-case CPU stall while the external side is continuously requesting:
- External reads: 2 cycles (one external read) plus the CPU's own read cycle.
- External writes: 1 cycle.
- The CPU always wins the next IDLE slot after an external grant, because the counter is then cleared.

## Structure
- Package `dmem_arb_pkg`:
  - `arb_state_t` enum {IDLE, CPU_RD, EXT_RD}.
  - `DMEM_ADDR_W`=32, `DMEM_DATA_W`=32.
- One sub-module `arb_starve_ctr`: saturating counter with `inc`/`clr` inputs and an `expired` output (≥STARVE_LIMIT), parameterised by STARVE_LIMIT and CNT_W.
- The FSM, issue mux and stall logic stay in `dmem_arbiter`.

## Test plan
- CPU store addr 0x10, data 0xDEADBEEF, no external request → `mem_we`=1 same cycle, `cpu_stall`=0. Then CPU load 0x10 → `cpu_stall`=1 for one cycle, then `cpu_rdata`=0xDEADBEEF with `cpu_stall`=0.
- External write 0x24=0x12345678, then external read 0x24 → `ext_gnt` pulses; `ext_rvalid` one cycle after the read grant with `ext_rdata`=0x12345678.
- CPU issuing a store every cycle while `ext_req` is held (STARVE_LIMIT=4) → `ext_gnt` on the 5th cycle; `cpu_stall`=1 only in that cycle; counter back to 0.
- CPU load and external read asserted together in IDLE, counter 0 → CPU is served first (2 cycles), external granted in the next IDLE cycle, `ext_rvalid` the cycle after.
- `rst_n` asserted during EXT_RD → `ext_rvalid` never pulses; after release, `cpu_stall`=0 and `mem_re`=0 with no requests; state=IDLE.
